// File: rtl/wm_pkg.sv
// WM8731 shared constants: control-port register map, power-up write table,
// sequencer state types and the audio clocking plan used by the codec clock generator.
package wm_pkg;

    localparam logic [6:0] WM_DEV_ADDR = 7'h1A;

    localparam logic [6:0] R0  = 7'd0;
    localparam logic [6:0] R1  = 7'd1;
    localparam logic [6:0] R2  = 7'd2;
    localparam logic [6:0] R3  = 7'd3;
    localparam logic [6:0] R4  = 7'd4;
    localparam logic [6:0] R5  = 7'd5;
    localparam logic [6:0] R6  = 7'd6;
    localparam logic [6:0] R7  = 7'd7;
    localparam logic [6:0] R8  = 7'd8;
    localparam logic [6:0] R9  = 7'd9;
    localparam logic [6:0] R15 = 7'd15;

    localparam int unsigned NUM_WRITES = 11;
    localparam int unsigned WIDX_W     = 4;
    typedef logic [WIDX_W-1:0] widx_t;

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } wm_write_t;

    // Reset first, activate last: the codec must only go active once fully configured
    localparam wm_write_t WM_INIT_TABLE [NUM_WRITES] = '{
        '{R15, 9'h000},
        '{R0,  9'h017},
        '{R1,  9'h017},
        '{R2,  9'h079},
        '{R3,  9'h079},
        '{R4,  9'h012},
        '{R5,  9'h000},
        '{R6,  9'h000},
        '{R7,  9'h002},
        '{R8,  9'h000},
        '{R9,  9'h001}
    };

    // Codec clocking: I2S slave, 16-bit samples, 48 kHz, MCLK = 256 fs
    localparam int unsigned WM_MCLK_HZ     = 12_288_000;
    localparam int unsigned WM_FS_HZ       = 48_000;
    localparam int unsigned WM_MCLK_PER_FS = WM_MCLK_HZ / WM_FS_HZ;
    localparam int unsigned WM_BCLK_PER_FS = 32;
    localparam int unsigned WM_BCLK_DIV    = WM_MCLK_PER_FS / WM_BCLK_PER_FS;

    typedef enum logic [1:0] {
        CfgIdle,
        CfgRun,
        CfgDone,
        CfgErr
    } cfg_state_t;

    typedef enum logic [2:0] {
        FrIdle,
        FrStart,
        FrBits,
        FrAck,
        FrStop,
        FrGap
    } frame_state_t;

    function automatic logic [23:0] wm_frame_bytes(wm_write_t w);
        return {WM_DEV_ADDR, 1'b0, w.addr, w.data};
    endfunction

endpackage

// File: rtl/wm_i2c_frame.sv
// Two-wire frame engine: quarter-bit divider plus bit FSM that sends START, three bytes
// with ACK slots, STOP and an idle gap, driving SCL/SDA as open-drain enables.
module wm_i2c_frame
    import wm_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50_000_000,
    parameter int unsigned I2C_HZ = 100_000
) (
    input  logic        CLK_50,
    input  logic        RST,
    input  logic        go,
    input  logic [23:0] frame_bytes,
    output logic        ready,
    output logic        nack,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_in
);

    localparam int unsigned Q  = CLK_HZ / (4 * I2C_HZ);
    localparam int unsigned QW = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [QW-1:0] QMAX = QW'(Q - 1);

    if (Q < 1) begin : g_bad_rate
        $error("wm_i2c_frame: CLK_HZ too low for I2C_HZ, quarter-bit below one cycle");
    end

    frame_state_t  st_q, st_d;
    logic [1:0]    qtr_q, qtr_d;
    logic [QW-1:0] div_q, div_d;
    logic [2:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [23:0]   sh_q, sh_d;
    logic          nack_q, nack_d;
    logic          scl_q, scl_d;
    logic          sda_q, sda_d;
    logic          tick;
    logic          qtr_end;

    // Returns {scl_oe, sda_oe} for a given phase and quarter
    function automatic logic [1:0] line_drive(frame_state_t st, logic [1:0] qtr, logic bit_val);
        case (st)
            FrStart: return {qtr == 2'd3, qtr >= 2'd2};
            FrBits:  return {(qtr == 2'd0) || (qtr == 2'd3), ~bit_val};
            FrAck:   return {(qtr == 2'd0) || (qtr == 2'd3), 1'b0};
            FrStop:  return {qtr == 2'd0, qtr <= 2'd1};
            default: return 2'b00;
        endcase
    endfunction

    always_comb begin
        st_d   = st_q;
        qtr_d  = qtr_q;
        bit_d  = bit_q;
        byte_d = byte_q;
        sh_d   = sh_q;
        nack_d = nack_q;

        tick    = (st_q != FrIdle) && (div_q == QMAX);
        qtr_end = tick && (qtr_q == 2'd3);
        div_d   = ((st_q == FrIdle) || tick) ? '0 : div_q + QW'(1);
        ready   = (st_q == FrIdle) ||
                  (qtr_end && ((st_q == FrGap) || ((st_q == FrStop) && nack_q)));

        if (tick) begin
            qtr_d = qtr_q + 2'd1;
        end
        if (tick && (qtr_q == 2'd2) && (st_q == FrAck) && sda_in) begin
            nack_d = 1'b1;
        end

        if (qtr_end) begin
            case (st_q)
                FrStart: st_d = FrBits;
                FrBits: begin
                    sh_d = {sh_q[22:0], 1'b0};
                    if (bit_q == 3'd7) begin
                        st_d  = FrAck;
                        bit_d = '0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
                FrAck: begin
                    if (nack_q || (byte_q == 2'd2)) begin
                        st_d = FrStop;
                    end else begin
                        st_d   = FrBits;
                        byte_d = byte_q + 2'd1;
                    end
                end
                // An aborted frame skips the gap; nobody follows it
                FrStop:  st_d = nack_q ? FrIdle : FrGap;
                FrGap:   st_d = FrIdle;
                default: st_d = FrIdle;
            endcase
        end

        if (go && ready) begin
            st_d   = FrStart;
            qtr_d  = '0;
            div_d  = '0;
            bit_d  = '0;
            byte_d = '0;
            sh_d   = frame_bytes;
            nack_d = 1'b0;
        end

        {scl_d, sda_d} = line_drive(st_d, qtr_d, sh_d[23]);
    end

    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            st_q   <= FrIdle;
            qtr_q  <= '0;
            div_q  <= '0;
            bit_q  <= '0;
            byte_q <= '0;
            sh_q   <= '0;
            nack_q <= 1'b0;
            scl_q  <= 1'b0;
            sda_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            qtr_q  <= qtr_d;
            div_q  <= div_d;
            bit_q  <= bit_d;
            byte_q <= byte_d;
            sh_q   <= sh_d;
            nack_q <= nack_d;
            scl_q  <= scl_d;
            sda_q  <= sda_d;
        end
    end

    assign nack   = nack_q;
    assign scl_oe = scl_q;
    assign sda_oe = sda_q;

endmodule

// File: rtl/wm_codec_cfg.sv
// WM8731 power-up configuration sequencer: walks the init table, one two-wire frame per
// entry, and reports busy/done/ack_err.
module wm_codec_cfg
    import wm_pkg::*;
#(
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned I2C_HZ     = 100_000,
    parameter bit          AUTO_START = 1'b1
) (
    input  logic CLK_50,
    input  logic RST,
    input  logic start,
    output logic scl_oe,
    output logic sda_oe,
    input  logic sda_in,
    output logic busy,
    output logic done,
    output logic ack_err
);

    cfg_state_t  st_q, st_d;
    widx_t       idx_q, idx_d;
    widx_t       sel;
    logic        auto_q, auto_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        go;
    logic        ready;
    logic        nack;
    logic [23:0] frame_bytes;

    // idx counts writes already issued: write 0 leaves in the acceptance cycle
    always_comb begin
        st_d   = st_q;
        idx_d  = idx_q;
        auto_d = auto_q;
        busy_d = busy_q;
        done_d = done_q;
        err_d  = err_q;
        go     = 1'b0;
        sel    = (idx_q < widx_t'(NUM_WRITES)) ? idx_q : '0;

        case (st_q)
            CfgRun: begin
                if (ready) begin
                    if (nack) begin
                        st_d   = CfgErr;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                        err_d  = 1'b1;
                    end else if (idx_q == widx_t'(NUM_WRITES)) begin
                        st_d   = CfgDone;
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        go    = 1'b1;
                        idx_d = idx_q + widx_t'(1);
                    end
                end
            end
            default: begin
                if (start || auto_q) begin
                    st_d   = CfgRun;
                    busy_d = 1'b1;
                    done_d = 1'b0;
                    err_d  = 1'b0;
                    auto_d = 1'b0;
                    sel    = '0;
                    go     = 1'b1;
                    idx_d  = widx_t'(1);
                end
            end
        endcase

        frame_bytes = wm_frame_bytes(WM_INIT_TABLE[sel]);
    end

    always_ff @(posedge CLK_50 or posedge RST) begin
        if (RST) begin
            st_q   <= CfgIdle;
            idx_q  <= '0;
            auto_q <= AUTO_START;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            idx_q  <= idx_d;
            auto_q <= auto_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    wm_i2c_frame #(
        .CLK_HZ (CLK_HZ),
        .I2C_HZ (I2C_HZ)
    ) u_frame (
        .CLK_50      (CLK_50),
        .RST         (RST),
        .go          (go),
        .frame_bytes (frame_bytes),
        .ready       (ready),
        .nack        (nack),
        .scl_oe      (scl_oe),
        .sda_oe      (sda_oe),
        .sda_in      (sda_in)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign ack_err = err_q;

endmodule

// File: tb/tb_wm_codec_cfg.sv
// Directed bench for wm_codec_cfg with Q=1: bus monitor with ACK/NACK slave model,
// frame capture, protocol and timing checks, plus an AUTO_START=0 instance.
module tb_wm_codec_cfg;

    logic clk;
    logic RST;
    logic start;
    logic scl_oe, sda_oe, sda_in, busy, done, ack_err;
    logic start_b;
    logic scl_oe_b, sda_oe_b, sda_in_b, busy_b, done_b, ack_err_b;

    int checks   = 0;
    int failures = 0;

    // Bus monitor / slave state
    bit          mscl, msda;
    bit          prev_scl = 1'b1;
    bit          prev_sda = 1'b1;
    bit          in_frame, seen_stop, slv_pull;
    bit          nack_en;
    int          nack_at;
    int          nstart, nstop, viol, gap_bad;
    int          bitcnt, bytecnt, hi, cyc, stop_cyc;
    logic [7:0]  shreg;
    logic [23:0] facc;
    logic [23:0] got[$];

    bit b_started  = 1'b0;
    bit b_activity = 1'b0;

    logic [23:0] exp_tab [11] = '{
        24'h341E00, 24'h340017, 24'h340217, 24'h340479, 24'h340679, 24'h340812,
        24'h340A00, 24'h340C00, 24'h340E02, 24'h341000, 24'h341201
    };

    assign sda_in   = ~(sda_oe | slv_pull);
    assign sda_in_b = ~sda_oe_b;

    wm_codec_cfg #(
        .CLK_HZ     (400_000),
        .I2C_HZ     (100_000),
        .AUTO_START (1'b1)
    ) dut (
        .CLK_50  (clk),
        .RST     (RST),
        .start   (start),
        .scl_oe  (scl_oe),
        .sda_oe  (sda_oe),
        .sda_in  (sda_in),
        .busy    (busy),
        .done    (done),
        .ack_err (ack_err)
    );

    wm_codec_cfg #(
        .CLK_HZ     (400_000),
        .I2C_HZ     (100_000),
        .AUTO_START (1'b0)
    ) dut_b (
        .CLK_50  (clk),
        .RST     (RST),
        .start   (start_b),
        .scl_oe  (scl_oe_b),
        .sda_oe  (sda_oe_b),
        .sda_in  (sda_in_b),
        .busy    (busy_b),
        .done    (done_b),
        .ack_err (ack_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        mscl = ~scl_oe;
        msda = ~(sda_oe | slv_pull);
        if (RST) begin
            in_frame  = 1'b0;
            seen_stop = 1'b0;
            slv_pull  = 1'b0;
            bitcnt    = 0;
        end else begin
            if (mscl && prev_scl && (msda != prev_sda)) begin
                if (!msda) begin
                    if (in_frame) viol++;
                    if (seen_stop && (cyc - stop_cyc < 8)) gap_bad++;
                    nstart++;
                    in_frame = 1'b1;
                    bitcnt   = 0;
                    bytecnt  = 0;
                end else begin
                    if (!in_frame || bitcnt != 1) viol++;
                    nstop++;
                    if (in_frame && bytecnt == 3) got.push_back(facc);
                    in_frame  = 1'b0;
                    seen_stop = 1'b1;
                    stop_cyc  = cyc;
                    bitcnt    = 0;
                end
            end else if (mscl && !prev_scl) begin
                bitcnt++;
                hi = 0;
                if (bitcnt <= 8) begin
                    shreg = {shreg[6:0], msda};
                end else begin
                    facc = {facc[15:0], shreg};
                    bytecnt++;
                end
            end else if (!mscl && prev_scl && bitcnt != 0) begin
                if (hi != 2) viol++;
                if (bitcnt == 8) slv_pull = !(nack_en && nstart == nack_at && bytecnt == 1);
                if (bitcnt == 9) begin
                    slv_pull = 1'b0;
                    bitcnt   = 0;
                end
            end
            if (mscl) hi++;
        end
        prev_scl = mscl;
        prev_sda = msda;
    end

    always @(negedge clk) begin
        if (!b_started && (busy_b || scl_oe_b || sda_oe_b)) b_activity = 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int from, input int limit, input int poke, output int n);
        n = from;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
            start = (n == poke);
        end
        start = 1'b0;
    endtask

    int cnt, base_s, base_p, base_g;

    initial begin
        RST = 1'b1; start = 1'b0; start_b = 1'b0; nack_en = 1'b0; nack_at = 0;
        repeat (3) @(negedge clk);
        chk("rst_scl_oe", scl_oe, 0);
        chk("rst_sda_oe", sda_oe, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ack_err", ack_err, 0);
        chk("rst_busy_b", busy_b, 0);

        // Auto-start run with a start pulse while busy
        base_s = nstart; base_p = nstop; base_g = got.size();
        RST = 1'b0;
        @(negedge clk);
        chk("auto_busy", busy, 1);
        wait_done(1, 3000, 300, cnt);
        chk("run1_cycles", (cnt >= 1318 && cnt <= 1322), 1);
        chk("run1_done", done, 1);
        chk("run1_busy", busy, 0);
        chk("run1_ack_err", ack_err, 0);
        chk("run1_nframes", got.size() - base_g, 11);
        chk("run1_nstart", nstart - base_s, 11);
        for (int k = 0; k < 11; k++) chk($sformatf("run1_frame%0d", k), got[base_g + k], exp_tab[k]);
        chk("run1_viol", viol, 0);
        chk("run1_gap", gap_bad, 0);

        // Restart from DONE
        repeat (5) @(negedge clk);
        base_g = got.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("rerun_done_clr", done, 0);
        chk("rerun_busy", busy, 1);
        wait_done(1, 3000, -1, cnt);
        chk("rerun_cycles", (cnt >= 1318 && cnt <= 1322), 1);
        chk("rerun_nframes", got.size() - base_g, 11);
        chk("rerun_first", got[base_g], 24'h341E00);
        chk("rerun_mid", got[base_g + 5], 24'h340812);
        chk("rerun_last", got[base_g + 10], 24'h341201);

        // NACK on byte1 of frame index 3
        repeat (5) @(negedge clk);
        base_s = nstart; base_p = nstop; base_g = got.size();
        nack_en = 1'b1; nack_at = nstart + 4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, 2000, -1, cnt);
        nack_en = 1'b0;
        chk("nack_cycles", (cnt >= 439 && cnt <= 443), 1);
        chk("nack_ack_err", ack_err, 1);
        chk("nack_done", done, 1);
        chk("nack_busy", busy, 0);
        chk("nack_nstart", nstart - base_s, 4);
        chk("nack_nstop", nstop - base_p, 4);
        chk("nack_nframes", got.size() - base_g, 3);
        chk("nack_lines", {scl_oe, sda_oe}, 0);

        // RST mid-byte in frame 5, then auto restart
        repeat (5) @(negedge clk);
        base_s = nstart;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_err_clr", ack_err, 0);
        repeat (652) @(negedge clk);
        chk("midrst_frame", nstart - base_s, 6);
        chk("midrst_scl_pre", scl_oe, 1);
        RST = 1'b1;
        #1;
        chk("midrst_scl", scl_oe, 0);
        chk("midrst_sda", sda_oe, 0);
        chk("midrst_busy", busy, 0);
        repeat (2) @(negedge clk);
        base_g = got.size();
        RST = 1'b0;
        @(negedge clk);
        chk("postrst_busy", busy, 1);
        wait_done(1, 3000, -1, cnt);
        chk("postrst_cycles", (cnt >= 1318 && cnt <= 1322), 1);
        chk("postrst_nframes", got.size() - base_g, 11);
        chk("postrst_first", got[base_g], 24'h341E00);
        chk("all_viol", viol, 0);
        chk("all_gap", gap_bad, 0);

        // AUTO_START=0 instance stayed idle until its first start
        chk("b_idle", b_activity, 0);
        chk("b_busy_idle", busy_b, 0);
        b_started = 1'b1;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        chk("b_busy", busy_b, 1);
        cnt = 0;
        while (!done_b && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("b_done", done_b, 1);
        chk("b_ack_err", ack_err_b, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
